// File: rtl/rv32i_pkg.sv
// Shared sizing, reset constants and types for the rename / commit-map block.
package rv32i_pkg;

  localparam int unsigned ARCH_REGS            = 32;
  localparam int unsigned PHYS_REGS            = 64;
  localparam int unsigned ARCH_REG_FILE_IDX_BW = $clog2(ARCH_REGS);
  localparam int unsigned PHYS_REG_FILE_IDX_BW = $clog2(PHYS_REGS);
  localparam int unsigned FREE_CNT_BW          = $clog2(PHYS_REGS) + 1;

  // Out of reset the identity mapping owns tags 0..ARCH_REGS-1; the rest are free.
  localparam logic [PHYS_REGS-1:0] FREE_MAP_RST =
    {{(PHYS_REGS - ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
  localparam logic [FREE_CNT_BW-1:0] FREE_CNT_RST = FREE_CNT_BW'(PHYS_REGS - ARCH_REGS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTORE = 2'd1,
    DRAIN   = 2'd2
  } rename_state_e;

  // Destination payload of a retiring ROB entry.
  typedef struct packed {
    logic                            vld;
    logic [ARCH_REG_FILE_IDX_BW-1:0] arch;
    logic [PHYS_REG_FILE_IDX_BW-1:0] tag;
  } retire_dst_t;

endpackage

// File: rtl/rv32i_free_list.sv
// Physical-tag free list: bitmap, lowest-free priority encoder and free counter.
module rv32i_free_list
  import rv32i_pkg::*;
(
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            alloc,
  input  logic                            free,
  input  logic [PHYS_REG_FILE_IDX_BW-1:0] free_tag,
  input  logic                            restore,
  input  logic [PHYS_REGS-1:0]            restore_map,
  output logic [PHYS_REG_FILE_IDX_BW-1:0] alloc_tag_c,
  output logic                            empty_c,
  output logic [FREE_CNT_BW-1:0]          free_count
);

  logic [PHYS_REGS-1:0]   free_map;
  logic [PHYS_REGS-1:0]   free_map_nxt;
  logic [FREE_CNT_BW-1:0] restore_cnt;
  logic [FREE_CNT_BW-1:0] free_count_nxt;

  // Lowest-index free tag; scanning downward lets the lowest set bit win.
  always_comb begin
    alloc_tag_c = '0;
    for (int i = int'(PHYS_REGS) - 1; i >= 0; i--) begin
      if (free_map[i]) alloc_tag_c = PHYS_REG_FILE_IDX_BW'(i);
    end
    empty_c = ~|free_map;
  end

  // Population count of the rebuilt map used after a restore.
  always_comb begin
    restore_cnt = '0;
    for (int i = 0; i < int'(PHYS_REGS); i++) begin
      restore_cnt = restore_cnt + FREE_CNT_BW'(restore_map[i]);
    end
  end

  // Allocate and free touch different bits (a freed tag is never free already).
  always_comb begin
    free_map_nxt   = free_map;
    free_count_nxt = free_count + FREE_CNT_BW'(free) - FREE_CNT_BW'(alloc);
    if (alloc) free_map_nxt[alloc_tag_c] = 1'b0;
    if (free)  free_map_nxt[free_tag]    = 1'b1;
    if (restore) begin
      free_map_nxt   = restore_map;
      free_count_nxt = restore_cnt;
    end
  end

  // Bitmap and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      free_map   <= FREE_MAP_RST;
      free_count <= FREE_CNT_RST;
    end else begin
      free_map   <= free_map_nxt;
      free_count <= free_count_nxt;
    end
  end

endmodule

// File: rtl/rv32i_rename_commit_map.sv
// Rename front end (speculative RAT + allocation) and commit back end
// (committed RAT + tag release), with exception recovery from the committed map.
module rv32i_rename_commit_map
  import rv32i_pkg::*;
(
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            i_rename_req,
  input  logic                            i_dst_vld,
  input  logic [ARCH_REG_FILE_IDX_BW-1:0] i_dst_arch_rf_idx,
  input  logic [ARCH_REG_FILE_IDX_BW-1:0] i_src1_arch_rf_idx,
  input  logic [ARCH_REG_FILE_IDX_BW-1:0] i_src2_arch_rf_idx,
  output logic [PHYS_REG_FILE_IDX_BW-1:0] o_src1_phys_rf_tag,
  output logic [PHYS_REG_FILE_IDX_BW-1:0] o_src2_phys_rf_tag,
  output logic [PHYS_REG_FILE_IDX_BW-1:0] o_dst_phys_rf_tag,
  output logic                            o_rename_ack,
  output logic                            o_stall,
  input  logic                            i_retire,
  input  logic                            i_except_vld,
  input  logic                            i_rob_flush,
  input  logic                            i_retire_dst_vld,
  input  logic [PHYS_REG_FILE_IDX_BW-1:0] i_retire_dst_phys_rf_tag,
  input  logic [ARCH_REG_FILE_IDX_BW-1:0] i_retire_dst_arch_rf_idx,
  output logic [FREE_CNT_BW-1:0]          o_free_count
);

  logic [PHYS_REG_FILE_IDX_BW-1:0] spec_rat [ARCH_REGS];
  logic [PHYS_REG_FILE_IDX_BW-1:0] comm_rat [ARCH_REGS];

  rename_state_e state;
  rename_state_e state_nxt;

  retire_dst_t                     ret;
  logic                            need_dst;
  logic                            alloc;
  logic                            retire_ok;
  logic                            restore;
  logic                            empty;
  logic [PHYS_REG_FILE_IDX_BW-1:0] alloc_tag;
  logic [PHYS_REG_FILE_IDX_BW-1:0] old_tag;
  logic [PHYS_REGS-1:0]            restore_map;

  assign ret = '{vld:  i_retire_dst_vld,
                 arch: i_retire_dst_arch_rf_idx,
                 tag:  i_retire_dst_phys_rf_tag};

  // Front-end handshake: x0 never needs a tag; stall covers recovery and exhaustion.
  assign need_dst           = i_dst_vld & (i_dst_arch_rf_idx != '0);
  assign o_stall            = (state != IDLE) | i_except_vld | (need_dst & empty);
  assign o_rename_ack       = i_rename_req & ~o_stall;
  assign alloc              = o_rename_ack & need_dst;
  assign o_dst_phys_rf_tag  = need_dst ? alloc_tag : '0;
  assign o_src1_phys_rf_tag = spec_rat[i_src1_arch_rf_idx];
  assign o_src2_phys_rf_tag = spec_rat[i_src2_arch_rf_idx];

  // A retire counts only in normal operation; the excepting instruction never commits.
  assign retire_ok = i_retire & (state == IDLE) & ~i_rob_flush & ~i_except_vld &
                     ret.vld & (ret.arch != '0);
  assign old_tag   = comm_rat[ret.arch];
  assign restore   = (state == RESTORE);

  // Free map rebuilt from the committed RAT: every tag not held architecturally.
  always_comb begin
    restore_map = '1;
    for (int i = 0; i < int'(ARCH_REGS); i++) begin
      restore_map[comm_rat[i]] = 1'b0;
    end
    restore_map[0] = 1'b0;
  end

  rv32i_free_list u_free_list (
    .clk         (clk),
    .rstn        (rstn),
    .alloc       (alloc),
    .free        (retire_ok),
    .free_tag    (old_tag),
    .restore     (restore),
    .restore_map (restore_map),
    .alloc_tag_c (alloc_tag),
    .empty_c     (empty),
    .free_count  (o_free_count)
  );

  // Recovery state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Recovery sequencing: one restore cycle, then wait out the ROB flush.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_except_vld) state_nxt = RESTORE;
      RESTORE: state_nxt = DRAIN;
      DRAIN:   if (!i_rob_flush) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Speculative RAT: restored wholesale on recovery, else updated by allocation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(ARCH_REGS); i++) spec_rat[i] <= PHYS_REG_FILE_IDX_BW'(i);
    end else if (restore) begin
      for (int i = 0; i < int'(ARCH_REGS); i++) spec_rat[i] <= comm_rat[i];
    end else if (alloc) begin
      spec_rat[i_dst_arch_rf_idx] <= alloc_tag;
    end
  end

  // Committed RAT: follows qualified retires only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(ARCH_REGS); i++) comm_rat[i] <= PHYS_REG_FILE_IDX_BW'(i);
    end else if (retire_ok) begin
      comm_rat[ret.arch] <= ret.tag;
    end
  end

endmodule

// File: tb/tb_rv32i_rename_commit_map.sv
// Bench for rv32i_rename_commit_map: directed vector table, recovery and
// exhaustion sequences, and randomized traffic against a reference model.
module tb_rv32i_rename_commit_map;
  import rv32i_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rename_req, dst_vld, retire, except_vld, rob_flush, ret_dst_vld;
  logic [4:0] dst_idx, src1_idx, src2_idx, ret_arch;
  logic [5:0] ret_tag;
  logic [5:0] src1_tag, src2_tag, dst_tag;
  logic       rename_ack, stall;
  logic [6:0] free_count;

  rv32i_rename_commit_map dut (
    .clk                      (clk),
    .rstn                     (rstn),
    .i_rename_req             (rename_req),
    .i_dst_vld                (dst_vld),
    .i_dst_arch_rf_idx        (dst_idx),
    .i_src1_arch_rf_idx       (src1_idx),
    .i_src2_arch_rf_idx       (src2_idx),
    .o_src1_phys_rf_tag       (src1_tag),
    .o_src2_phys_rf_tag       (src2_tag),
    .o_dst_phys_rf_tag        (dst_tag),
    .o_rename_ack             (rename_ack),
    .o_stall                  (stall),
    .i_retire                 (retire),
    .i_except_vld             (except_vld),
    .i_rob_flush              (rob_flush),
    .i_retire_dst_vld         (ret_dst_vld),
    .i_retire_dst_phys_rf_tag (ret_tag),
    .i_retire_dst_arch_rf_idx (ret_arch),
    .o_free_count             (free_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  int m_spec [32];
  int m_comm [32];
  bit m_free [64];
  int m_phase;   // 0 = renaming, 1 = restoring this cycle, 2 = waiting for flush end

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin m_spec[i] = i; m_comm[i] = i; end
    for (int p = 0; p < 64; p++) m_free[p] = (p >= 32);
    m_phase = 0;
  endfunction

  function automatic int m_lowest();
    for (int p = 0; p < 64; p++) if (m_free[p]) return p;
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int p = 0; p < 64; p++) c += int'(m_free[p]);
    return c;
  endfunction

  function automatic bit m_need();
    return dst_vld && (dst_idx != 5'd0);
  endfunction

  function automatic void m_check();
    int  lo     = m_lowest();
    bit  need   = m_need();
    bit  e_stall = (m_phase != 0) || except_vld || (need && lo < 0);
    bit  e_ack  = rename_req && !e_stall;
    chk("stall", int'(stall), int'(e_stall));
    chk("ack", int'(rename_ack), int'(e_ack));
    if (e_ack) chk("dst_tag", int'(dst_tag), need ? lo : 0);
    chk("src1_tag", int'(src1_tag), m_spec[src1_idx]);
    chk("src2_tag", int'(src2_tag), m_spec[src2_idx]);
  endfunction

  function automatic void m_step();
    int lo, old;
    if (m_phase == 1) begin
      for (int i = 0; i < 32; i++) m_spec[i] = m_comm[i];
      for (int p = 0; p < 64; p++) m_free[p] = 1'b1;
      for (int i = 0; i < 32; i++) m_free[m_comm[i]] = 1'b0;
      m_free[0] = 1'b0;
      m_phase = 2;
    end else if (m_phase == 2) begin
      if (!rob_flush) m_phase = 0;
    end else if (except_vld) begin
      m_phase = 1;
    end else begin
      lo = m_lowest();
      if (rename_req && m_need() && lo >= 0) begin
        m_spec[dst_idx] = lo;
        m_free[lo] = 1'b0;
      end
      if (retire && !rob_flush && ret_dst_vld && ret_arch != 5'd0) begin
        old = m_comm[ret_arch];
        m_comm[ret_arch] = int'(ret_tag);
        m_free[old] = 1'b1;
      end
    end
  endfunction

  // One clock: check combinational outputs mid-phase, advance model, check counter.
  task automatic tick();
    #2;
    m_check();
    @(posedge clk);
    m_step();
    @(negedge clk);
    chk("free_count", int'(free_count), m_count());
  endtask

  task automatic clear_in();
    rename_req = 0; dst_vld = 0; dst_idx = 0; src1_idx = 0; src2_idx = 0;
    retire = 0; except_vld = 0; rob_flush = 0; ret_dst_vld = 0; ret_tag = 0; ret_arch = 0;
  endtask

  task automatic set_in(input bit rq, input bit dv, input int d, input int s1, input int s2,
                        input bit rt, input bit fl, input bit rdv, input int tg, input int ar);
    rename_req = rq; dst_vld = dv; dst_idx = 5'(d); src1_idx = 5'(s1); src2_idx = 5'(s2);
    retire = rt; rob_flush = fl; ret_dst_vld = rdv; ret_tag = 6'(tg); ret_arch = 5'(ar);
    except_vld = 0;
  endtask

  task automatic do_reset();
    clear_in();
    rstn = 0;
    m_reset();
    repeat (2) @(negedge clk);
    rstn = 1;
    #1;
    chk("rst_free_count", int'(free_count), 32);
    chk("rst_ack", int'(rename_ack), 0);
    chk("rst_stall", int'(stall), 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit req; bit dv; int dst; int s1; int s2;
    bit rt; bit fl; bit rdv; int rtag; int rarch;
    int e_ack; int e_stall; int e_dst; int e_s1; int e_s2; int e_cnt;
  } vec_t;

  function automatic vec_t mk(bit req, bit dv, int dst, int s1, int s2,
                              bit rt, bit fl, bit rdv, int rtag, int rarch,
                              int e_ack, int e_stall, int e_dst, int e_s1, int e_s2, int e_cnt);
    vec_t v;
    v.req = req; v.dv = dv; v.dst = dst; v.s1 = s1; v.s2 = s2;
    v.rt = rt; v.fl = fl; v.rdv = rdv; v.rtag = rtag; v.rarch = rarch;
    v.e_ack = e_ack; v.e_stall = e_stall; v.e_dst = e_dst;
    v.e_s1 = e_s1; v.e_s2 = e_s2; v.e_cnt = e_cnt;
    return v;
  endfunction

  vec_t tbl [13];
  int   flush_left;
  int   q_arch [$];
  int   q_tag  [$];

  initial begin
    rstn = 0;
    clear_in();

    //             req dv dst s1 s2  rt fl rdv tag arch   ack st dst s1 s2 cnt
    tbl[0]  = mk(1, 1, 5,  5, 3,  0, 0, 0, 0,  0,      1, 0, 32, 5,  3, 31);
    tbl[1]  = mk(1, 1, 5,  5, 0,  0, 0, 0, 0,  0,      1, 0, 33, 32, 0, 30);
    tbl[2]  = mk(0, 0, 0,  5, 0,  1, 0, 1, 32, 5,      0, 0, 0,  33, 0, 31);
    tbl[3]  = mk(0, 0, 0,  5, 0,  1, 0, 1, 33, 5,      0, 0, 0,  33, 0, 32);
    tbl[4]  = mk(1, 1, 7,  5, 7,  0, 0, 0, 0,  0,      1, 0, 5,  33, 7, 31);
    tbl[5]  = mk(1, 1, 0,  7, 0,  0, 0, 0, 0,  0,      1, 0, 0,  5,  0, 31);
    tbl[6]  = mk(0, 0, 0,  7, 0,  1, 0, 1, 40, 0,      0, 0, 0,  5,  0, 31);
    tbl[7]  = mk(1, 1, 8,  8, 7,  1, 0, 1, 5,  7,      1, 0, 32, 8,  5, 31);
    tbl[8]  = mk(1, 1, 9,  8, 0,  0, 0, 0, 0,  0,      1, 0, 7,  32, 0, 30);
    tbl[9]  = mk(0, 0, 0,  8, 9,  1, 1, 1, 32, 8,      0, 0, 0,  32, 7, 30);
    tbl[10] = mk(0, 0, 0,  8, 0,  1, 0, 1, 32, 8,      0, 0, 0,  32, 0, 31);
    tbl[11] = mk(1, 1, 10, 10, 9, 0, 0, 0, 0,  0,      1, 0, 8,  10, 7, 30);
    tbl[12] = mk(1, 0, 11, 11, 0, 0, 0, 0, 0,  0,      1, 0, 0,  11, 0, 30);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].req, tbl[i].dv, tbl[i].dst, tbl[i].s1, tbl[i].s2,
             tbl[i].rt, tbl[i].fl, tbl[i].rdv, tbl[i].rtag, tbl[i].rarch);
      #1;
      chk($sformatf("vec%0d_ack", i), int'(rename_ack), tbl[i].e_ack);
      chk($sformatf("vec%0d_stall", i), int'(stall), tbl[i].e_stall);
      chk($sformatf("vec%0d_dst", i), int'(dst_tag), tbl[i].e_dst);
      chk($sformatf("vec%0d_src1", i), int'(src1_tag), tbl[i].e_s1);
      chk($sformatf("vec%0d_src2", i), int'(src2_tag), tbl[i].e_s2);
      tick();
      chk($sformatf("vec%0d_count", i), int'(free_count), tbl[i].e_cnt);
    end

    // ---------------- free-list exhaustion ----------------
    do_reset();
    for (int i = 0; i < 32; i++) begin
      set_in(1, 1, (i % 31) + 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    chk("exh_count", int'(free_count), 0);
    set_in(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("exh_stall", int'(stall), 1);
    chk("exh_ack", int'(rename_ack), 0);
    tick();
    set_in(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("exh_nodst_ack", int'(rename_ack), 1);
    tick();
    set_in(1, 1, 4, 0, 0, 1, 0, 1, 32, 1);
    #1;
    chk("exh_stall_retire_cycle", int'(stall), 1);
    tick();
    set_in(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("exh_stall_cleared", int'(stall), 0);
    chk("exh_dst_after_free", int'(dst_tag), 1);
    tick();

    // ---------------- exception recovery ----------------
    do_reset();
    set_in(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    set_in(1, 1, 2, 0, 0, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 1, 0, 1, 32, 1); tick();
    clear_in(); except_vld = 1;
    #1;
    chk("rec_except_stall", int'(stall), 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 6, 0, 0, 1, 1, 1, 33, 2);
      #1;
      chk($sformatf("rec_flush%0d_stall", i), int'(stall), 1);
      tick();
    end
    chk("rec_count", int'(free_count), 32);
    set_in(1, 1, 6, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rec_drain_exit_stall", int'(stall), 1);
    tick();
    set_in(1, 1, 3, 2, 1, 0, 0, 0, 0, 0);
    #1;
    chk("rec_resume_stall", int'(stall), 0);
    chk("rec_x2_restored", int'(src1_tag), 2);
    chk("rec_x1_committed", int'(src2_tag), 32);
    chk("rec_tag1_free", int'(dst_tag), 1);
    tick();
    set_in(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rec_tag33_free", int'(dst_tag), 33);
    tick();

    // ---------------- reset asserted during restore ----------------
    do_reset();
    set_in(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    clear_in(); except_vld = 1; tick();
    clear_in(); src1_idx = 5'd1;
    #2;
    rstn = 0;
    #1;
    chk("rst_restore_count", int'(free_count), 32);
    chk("rst_restore_stall", int'(stall), 0);
    chk("rst_restore_x1", int'(src1_tag), 1);
    m_reset();
    @(negedge clk);
    rstn = 1;
    set_in(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    tick();

    // ---------------- randomized traffic ----------------
    do_reset();
    flush_left = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      clear_in();
      rename_req = 1'($urandom_range(0, 3) != 0);
      dst_vld    = 1'($urandom_range(0, 1));
      dst_idx    = 5'($urandom_range(0, 31));
      src1_idx   = 5'($urandom_range(0, 31));
      src2_idx   = 5'($urandom_range(0, 31));
      if (flush_left > 0) begin
        rob_flush   = 1;
        flush_left--;
        retire      = 1'($urandom_range(0, 1));
        ret_dst_vld = 1;
        ret_arch    = 5'($urandom_range(0, 31));
        ret_tag     = 6'($urandom_range(0, 63));
      end else if (m_phase == 0 && q_arch.size() > 0 && $urandom_range(0, 49) == 0) begin
        except_vld = 1;
        flush_left = $urandom_range(1, 4);
        q_arch.delete();
        q_tag.delete();
      end else begin
        if (q_arch.size() > 0 && $urandom_range(0, 2) == 0) begin
          retire      = 1;
          ret_dst_vld = 1;
          ret_arch    = 5'(q_arch.pop_front());
          ret_tag     = 6'(q_tag.pop_front());
        end else if ($urandom_range(0, 3) == 0) begin
          retire      = 1;
          ret_dst_vld = 1'($urandom_range(0, 1));
          ret_arch    = ret_dst_vld ? 5'd0 : 5'($urandom_range(0, 31));
          ret_tag     = 6'($urandom_range(0, 63));
        end
        if (m_phase == 0 && rename_req && m_need() && m_lowest() >= 0) begin
          q_arch.push_back(int'(dst_idx));
          q_tag.push_back(m_lowest());
        end
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
